// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle IF/ID/EXE/MEM/WB sequencer that drives PC, IR, regfile and SRAM strobes.
// Latency: MEM_LAT+3 (ALU/branch), MEM_LAT+4 (store), 2*MEM_LAT+3 (load) cycles per instruction.
// Backpressure: SRAM read latency is absorbed by IFW/MEMW wait states; halt_req parks the walk in HALT.
module multicycle_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_is_load,
  input  logic             inst_is_store,
  input  logic             inst_gr_we,
  input  logic             inst_is_branch,
  input  logic             br_taken,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             inst_sram_en,
  output logic             ir_we,
  output logic             data_sram_en,
  output logic             data_sram_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_IFW  = 3'd6,
    S_MEMW = 3'd7
  } state_t;

  // Wait states needed beyond the strobe cycle itself; the counter runs down to 0.
  localparam int         WAIT_INT  = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
  localparam logic [2:0] WAIT_INIT = WAIT_INT[2:0];

  state_t     st;
  logic       valid;
  logic       is_load_q;
  logic       is_store_q;
  logic       gr_we_q;
  logic [2:0] wait_cnt;
  logic       act;

  assign state = st;
  // Strobes only fire once out of reset and after the start-up cycle has set valid.
  assign act   = resetn & valid;

  // Sequencer state, latched instruction class, wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st         <= S_IF;
      valid      <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      gr_we_q    <= 1'b0;
      wait_cnt   <= 3'd0;
      retire_cnt <= '0;
    end else begin
      valid <= 1'b1;
      if (valid) begin
        case (st)
          S_IF: begin
            if (MEM_LAT == 1) begin
              st <= S_ID;
            end else begin
              st       <= S_IFW;
              wait_cnt <= WAIT_INIT;
            end
          end
          S_IFW: begin
            if (wait_cnt == 3'd0) st <= S_ID;
            else                  wait_cnt <= wait_cnt - 3'd1;
          end
          S_ID: begin
            st <= S_EXE;
          end
          S_EXE: begin
            // A malformed decode with both load and store set is treated as a store.
            is_store_q <= inst_is_store;
            is_load_q  <= inst_is_load & ~inst_is_store;
            gr_we_q    <= inst_gr_we;
            st         <= (inst_is_load | inst_is_store) ? S_MEM : S_WB;
          end
          S_MEM: begin
            if (is_load_q && (MEM_LAT > 1)) begin
              st       <= S_MEMW;
              wait_cnt <= WAIT_INIT;
            end else begin
              st <= S_WB;
            end
          end
          S_MEMW: begin
            if (wait_cnt == 3'd0) st <= S_WB;
            else                  wait_cnt <= wait_cnt - 3'd1;
          end
          S_WB: begin
            retire_cnt <= retire_cnt + CNT_W'(1);
            st         <= halt_req ? S_HALT : S_IF;
          end
          S_HALT: begin
            if (!halt_req) st <= S_IF;
          end
        endcase
      end
    end
  end

  // Moore strobe decode of the current state, forced quiet during reset and start-up.
  always_comb begin
    inst_sram_en = 1'b0;
    ir_we        = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    if (act) begin
      case (st)
        S_IF:   inst_sram_en = 1'b1;
        S_ID:   ir_we        = 1'b1;
        S_MEM: begin
          data_sram_en = 1'b1;
          data_sram_we = is_store_q;
        end
        S_WB: begin
          pc_we  = 1'b1;
          pc_sel = inst_is_branch & br_taken;
          retire = 1'b1;
          rf_we  = gr_we_q & ~is_store_q;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // The PC, IR, fetch and data strobes belong to distinct states and never overlap.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0({pc_we, ir_we, inst_sram_en, data_sram_en}));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: scoreboard bench for multicycle_ctrl at MEM_LAT 1, 3 and 2 (2-bit counter for wrap).
// Latency: expected per-instruction state trace and strobe counts are checked at each retire.
// Backpressure: n/a; instances not under test are held in reset.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn [3];
  logic is_load, is_store, gr_we, is_branch, taken, halt_req;

  logic [2:0] st  [3];
  logic       ise [3];
  logic       irw [3];
  logic       dse [3];
  logic       dsw [3];
  logic       rfw [3];
  logic       pcw [3];
  logic       pcs [3];
  logic       ret [3];
  logic       hlt [3];
  logic [31:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] trace;
    int          len;
    logic        dwe;
    logic        rf;
    logic        psel;
    int          mem_en;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] exp_cnt [3];

  multicycle_ctrl #(.MEM_LAT(1), .CNT_W(32)) u0 (
    .clk(clk), .resetn(rn[0]), .inst_is_load(is_load), .inst_is_store(is_store),
    .inst_gr_we(gr_we), .inst_is_branch(is_branch), .br_taken(taken), .halt_req(halt_req),
    .state(st[0]), .inst_sram_en(ise[0]), .ir_we(irw[0]), .data_sram_en(dse[0]),
    .data_sram_we(dsw[0]), .rf_we(rfw[0]), .pc_we(pcw[0]), .pc_sel(pcs[0]),
    .retire(ret[0]), .retire_cnt(cnt0), .halted(hlt[0]));

  multicycle_ctrl #(.MEM_LAT(3), .CNT_W(32)) u1 (
    .clk(clk), .resetn(rn[1]), .inst_is_load(is_load), .inst_is_store(is_store),
    .inst_gr_we(gr_we), .inst_is_branch(is_branch), .br_taken(taken), .halt_req(halt_req),
    .state(st[1]), .inst_sram_en(ise[1]), .ir_we(irw[1]), .data_sram_en(dse[1]),
    .data_sram_we(dsw[1]), .rf_we(rfw[1]), .pc_we(pcw[1]), .pc_sel(pcs[1]),
    .retire(ret[1]), .retire_cnt(cnt1), .halted(hlt[1]));

  multicycle_ctrl #(.MEM_LAT(2), .CNT_W(2)) u2 (
    .clk(clk), .resetn(rn[2]), .inst_is_load(is_load), .inst_is_store(is_store),
    .inst_gr_we(gr_we), .inst_is_branch(is_branch), .br_taken(taken), .halt_req(halt_req),
    .state(st[2]), .inst_sram_en(ise[2]), .ir_we(irw[2]), .data_sram_en(dse[2]),
    .data_sram_we(dsw[2]), .rf_we(rfw[2]), .pc_we(pcw[2]), .pc_sel(pcs[2]),
    .retire(ret[2]), .retire_cnt(cnt2), .halted(hlt[2]));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int lat(input int k);
    if (k == 0) return 1;
    if (k == 1) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] get_cnt(input int k);
    if (k == 0) return cnt0;
    if (k == 1) return cnt1;
    return {30'd0, cnt2};
  endfunction

  function automatic logic [6:0] strobes(input int k);
    return {ise[k], irw[k], dse[k], dsw[k], rfw[k], pcw[k], ret[k]};
  endfunction

  // Reference model: expected state walk and strobe summary for one instruction.
  task automatic push_exp(input int k, input bit ld, input bit sto, input bit gw,
                          input bit br, input bit tk);
    exp_t e;
    int   seq [$];
    int   l = lat(k);
    seq.push_back(0);
    for (int i = 0; i < l - 1; i++) seq.push_back(6);
    seq.push_back(1);
    seq.push_back(2);
    if (ld || sto) begin
      seq.push_back(3);
      if (ld && !sto) for (int i = 0; i < l - 1; i++) seq.push_back(7);
    end
    seq.push_back(4);
    e.trace = '0;
    foreach (seq[i]) e.trace = (e.trace << 3) | 64'(seq[i]);
    e.len    = seq.size();
    e.dwe    = sto;
    e.rf     = gw & ~sto;
    e.psel   = br & tk;
    e.mem_en = (ld || sto) ? 1 : 0;
    exp_cnt[k] = (k == 2) ? ((exp_cnt[k] + 32'd1) & 32'd3) : (exp_cnt[k] + 32'd1);
    e.cnt    = exp_cnt[k];
    sb.push_back(e);
  endtask

  // Issues one instruction from an IF cycle and scores it at retire.
  task automatic run_insn(input int k, input bit ld, input bit sto, input bit gw,
                          input bit br, input bit tk, input bit halt_at_exe);
    exp_t        e;
    logic [63:0] tr = '0;
    int          len = 0, n_rf = 0, n_pc = 0, n_if = 0, n_ir = 0, n_de = 0, n_dw = 0;
    logic        dwe_mem = 1'b0, psel_wb = 1'b0;
    bit          done = 1'b0;
    is_load = ld; is_store = sto; gr_we = gw; is_branch = br; taken = tk;
    push_exp(k, ld, sto, gw, br, tk);
    for (int c = 0; c < 40 && !done; c++) begin
      tr = (tr << 3) | 64'(st[k]);
      len++;
      n_rf += int'(rfw[k]);
      n_pc += int'(pcw[k]);
      n_if += int'(ise[k]);
      n_ir += int'(irw[k]);
      n_de += int'(dse[k]);
      n_dw += int'(dsw[k]);
      if (dse[k] && dsw[k]) dwe_mem = 1'b1;
      if (pcw[k]) psel_wb = pcs[k];
      if (halt_at_exe && st[k] == 3'd2) halt_req = 1'b1;
      if (ret[k]) done = 1'b1;
      else        step();
    end
    if (!done) check("retire_timeout", 64'd0, 64'd1);
    e = sb.pop_front();
    check("state_trace", tr, e.trace);
    check("cycles", 64'(len), 64'(e.len));
    check("dsram_we_in_mem", 64'(dwe_mem), 64'(e.dwe));
    check("dsram_we_count", 64'(n_dw), 64'(e.dwe));
    check("rf_we_count", 64'(n_rf), 64'(e.rf));
    check("pc_sel_wb", 64'(psel_wb), 64'(e.psel));
    check("pc_we_count", 64'(n_pc), 64'd1);
    check("fetch_count", 64'(n_if), 64'd1);
    check("ir_we_count", 64'(n_ir), 64'd1);
    check("dsram_en_count", 64'(n_de), 64'(e.mem_en));
    step();
    check("retire_cnt", 64'(get_cnt(k)), 64'(e.cnt));
  endtask

  task automatic start(input int k);
    rn[k] = 1'b1;
    for (int c = 0; c < 10 && !ise[k]; c++) step();
    check("start_fetch", 64'(ise[k]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    for (int k = 0; k < 3; k++) begin
      rn[k] = 1'b0;
      exp_cnt[k] = '0;
    end
    is_load = 0; is_store = 0; gr_we = 0; is_branch = 0; taken = 0; halt_req = 0;
    @(negedge clk);
    repeat (3) step();

    // Reset state of the MEM_LAT=1 instance.
    check("rst_state", 64'(st[0]), 64'd0);
    check("rst_strobes", 64'(strobes(0)), 64'd0);
    check("rst_cnt", 64'(cnt0), 64'd0);
    check("rst_halted", 64'(hlt[0]), 64'd0);

    // Release: first cycle with resetn high is still idle, fetch follows one cycle later.
    rn[0] = 1'b1;
    #1 check("startup_no_fetch", 64'(ise[0]), 64'd0);
    step();
    check("first_fetch", 64'(ise[0]), 64'd1);

    // add.w stream.
    for (int i = 0; i < 3; i++) run_insn(0, 0, 0, 1, 0, 0, 0);
    check("add_cnt3", 64'(cnt0), 64'd3);

    // beq taken, bne not taken.
    run_insn(0, 0, 0, 0, 1, 1, 0);
    run_insn(0, 0, 0, 0, 1, 0, 0);

    // st.w with load also decoded: store wins, no regfile write.
    run_insn(0, 1, 1, 1, 0, 0, 0);

    // Halt requested during EXE and held for five cycles.
    run_insn(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("halt_state", 64'(st[0]), 64'd5);
      check("halt_flag", 64'(hlt[0]), 64'd1);
      check("halt_strobes", 64'(strobes(0)), 64'd0);
      check("halt_cnt", 64'(cnt0), 64'(exp_cnt[0]));
      if (i < 2) step();
    end
    halt_req = 1'b0;
    step();
    check("resume_state", 64'(st[0]), 64'd0);
    check("resume_fetch", 64'(ise[0]), 64'd1);
    rn[0] = 1'b0;

    // MEM_LAT=3 load.
    start(1);
    run_insn(1, 1, 0, 1, 0, 0, 0);
    rn[1] = 1'b0;

    // MEM_LAT=2, 2-bit counter: reset during a store's MEM cycle, then wrap.
    start(2);
    run_insn(2, 0, 0, 1, 0, 0, 0);
    is_load = 0; is_store = 1; gr_we = 0; is_branch = 0; taken = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (st[2] == 3'd3) found = 1'b1;
      else               step();
    end
    check("reach_mem", 64'(found), 64'd1);
    rn[2] = 1'b0;
    #1;
    check("rst_mem_dsram_we", 64'(dsw[2]), 64'd0);
    check("rst_mem_strobes", 64'(strobes(2)), 64'd0);
    step();
    check("rst_mem_state", 64'(st[2]), 64'd0);
    check("rst_mem_cnt", 64'(cnt2), 64'd0);
    exp_cnt[2] = '0;
    start(2);
    for (int i = 0; i < 4; i++) run_insn(2, 0, 0, 1, 0, 0, 0);
    check("cnt_wrap", 64'(cnt2), 64'd0);
    rn[2] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
